// File: rtl/mc_controller_pkg.sv
// Shared definitions for the multicycle MIPS control FSM: opcodes, functs,
// state codes and datapath select encodings.
package mc_controller_pkg;

    localparam int STW  = 4;
    localparam int ALUW = 3;

    typedef enum logic [STW-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_MULT   = 4'd12,
        S_MFWB   = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD    = 6'b100000;
    localparam logic [5:0] F_SUB    = 6'b100010;
    localparam logic [5:0] F_AND    = 6'b100100;
    localparam logic [5:0] F_OR     = 6'b100101;
    localparam logic [5:0] F_SLT    = 6'b101010;
    localparam logic [5:0] F_MULTU  = 6'b011001;
    localparam logic [5:0] F_MFHI   = 6'b010000;
    localparam logic [5:0] F_MFLO   = 6'b010010;

    localparam logic [ALUW-1:0] ALU_AND = 3'b000;
    localparam logic [ALUW-1:0] ALU_OR  = 3'b001;
    localparam logic [ALUW-1:0] ALU_ADD = 3'b010;
    localparam logic [ALUW-1:0] ALU_SUB = 3'b110;
    localparam logic [ALUW-1:0] ALU_SLT = 3'b111;

    // aluop 11 is the idle code: states that do not use the ALU drive alu_ctrl to 000
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_IDLE  = 2'b11;

    localparam logic [1:0] WD_ALUOUT = 2'b00;
    localparam logic [1:0] WD_MDR    = 2'b01;
    localparam logic [1:0] WD_HI     = 2'b10;
    localparam logic [1:0] WD_LO     = 2'b11;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_controller_if.sv
// Control bus between the multicycle FSM (master) and the MIPS datapath (slave).
interface mc_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pc_en;
    logic       iord;
    logic       mem_we;
    logic       ir_we;
    logic       reg_dst;
    logic       reg_we;
    logic [1:0] wd_sel;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic [1:0] pc_src;
    logic       hilo_we;

    modport master (
        input  op, funct, zero,
        output pc_en, iord, mem_we, ir_we, reg_dst, reg_we, wd_sel,
               alu_src_a, alu_src_b, alu_ctrl, pc_src, hilo_we
    );

    modport slave (
        output op, funct, zero,
        input  pc_en, iord, mem_we, ir_we, reg_dst, reg_we, wd_sel,
               alu_src_a, alu_src_b, alu_ctrl, pc_src, hilo_we
    );
endinterface

// File: rtl/mc_controller_alu_decoder.sv
// ALU decoder: maps the FSM's aluop request plus the R-type funct field to alu_ctrl.
module mc_controller_alu_decoder
    import mc_controller_pkg::*;
(
    input  logic [1:0]      aluop,
    input  logic [5:0]      funct,
    output logic [ALUW-1:0] alu_ctrl
);

    always_comb begin
        alu_ctrl = ALU_AND;
        case (aluop)
            ALUOP_ADD: alu_ctrl = ALU_ADD;
            ALUOP_SUB: alu_ctrl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    F_ADD:   alu_ctrl = ALU_ADD;
                    F_SUB:   alu_ctrl = ALU_SUB;
                    F_AND:   alu_ctrl = ALU_AND;
                    F_OR:    alu_ctrl = ALU_OR;
                    F_SLT:   alu_ctrl = ALU_SLT;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            default: alu_ctrl = ALU_AND;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM: one state per clock, Moore outputs decoded from the
// state register (pc_en also sees zero, alu_ctrl/wd_sel also see funct).
module mc_controller
    import mc_controller_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    mc_controller_if.master bus,
    output logic [STW-1:0]  state
);

    state_t     state_q, state_d;
    logic [1:0] aluop;
    logic       pc_write, branch;
    logic       ir_we_raw, reg_we_raw, mem_we_raw, hilo_we_raw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d        = S_FETCH;
        pc_write       = 1'b0;
        branch         = 1'b0;
        ir_we_raw      = 1'b0;
        reg_we_raw     = 1'b0;
        mem_we_raw     = 1'b0;
        hilo_we_raw    = 1'b0;
        aluop          = ALUOP_IDLE;
        bus.iord       = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.wd_sel     = WD_ALUOUT;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = SRCB_B;
        bus.pc_src     = PCSRC_ALU;
        case (state_q)
            S_FETCH: begin
                ir_we_raw     = 1'b1;
                bus.alu_src_b = SRCB_FOUR;
                aluop         = ALUOP_ADD;
                pc_write      = 1'b1;
                state_d       = S_DECODE;
            end
            S_DECODE: begin
                // precompute the branch target into ALUOut while op is decoded
                bus.alu_src_b = SRCB_IMMSH;
                aluop         = ALUOP_ADD;
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                aluop         = ALUOP_ADD;
                state_d       = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                bus.iord = 1'b1;
                state_d  = S_MEMWB;
            end
            S_MEMWB: begin
                reg_we_raw = 1'b1;
                bus.wd_sel = WD_MDR;
            end
            S_MEMWR: begin
                bus.iord   = 1'b1;
                mem_we_raw = 1'b1;
            end
            S_EXEC: begin
                bus.alu_src_a = 1'b1;
                aluop         = ALUOP_FUNCT;
                case (bus.funct)
                    F_ADD, F_SUB, F_AND, F_OR, F_SLT: state_d = S_ALUWB;
                    F_MULTU:                          state_d = S_MULT;
                    F_MFHI, F_MFLO:                   state_d = S_MFWB;
                    default:                          state_d = S_FETCH;
                endcase
            end
            S_ALUWB: begin
                bus.reg_dst = 1'b1;
                reg_we_raw  = 1'b1;
            end
            S_MULT: hilo_we_raw = 1'b1;
            S_MFWB: begin
                bus.reg_dst = 1'b1;
                reg_we_raw  = 1'b1;
                bus.wd_sel  = (bus.funct == F_MFHI) ? WD_HI : WD_LO;
            end
            S_BRANCH: begin
                bus.alu_src_a = 1'b1;
                aluop         = ALUOP_SUB;
                bus.pc_src    = PCSRC_ALUOUT;
                branch        = 1'b1;
            end
            S_ADDIEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                aluop         = ALUOP_ADD;
                state_d       = S_ADDIWB;
            end
            S_ADDIWB: reg_we_raw = 1'b1;
            S_JUMP: begin
                bus.pc_src = PCSRC_JUMP;
                pc_write   = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    mc_controller_alu_decoder u_alu_decoder (
        .aluop    (aluop),
        .funct    (bus.funct),
        .alu_ctrl (bus.alu_ctrl)
    );

    // Enables are masked by rst so nothing is written while reset is held
    assign bus.pc_en   = (pc_write | (branch & bus.zero)) & ~rst;
    assign bus.ir_we   = ir_we_raw & ~rst;
    assign bus.reg_we  = reg_we_raw & ~rst;
    assign bus.mem_we  = mem_we_raw & ~rst;
    assign bus.hilo_we = hilo_we_raw & ~rst;
    assign state       = state_q;

endmodule
